// File: rtl/sipo_pkg.sv
// Shared constants for the serial-in parallel-out deserializer.
package sipo_pkg;

  // Counter width for a given word width; two-bit words still need one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam logic PAR_RST_BIT   = 1'b0;
  localparam logic VALID_RST     = 1'b0;
  localparam logic OVERRUN_RST   = 1'b0;
  localparam logic BUSY_RST      = 1'b0;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear, load-to-1, enable and terminal count.
module mod_counter #(
  parameter int MOD = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load1,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(MOD - 1));

  // Priority: clear, then load-to-1, then count.
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (load1)
      cnt <= W'(1);
    else if (en)
      cnt <= tc ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Reassembles an MSB-first bit stream into WIDTH-bit words with a valid/ack
// output register and a sticky overrun flag.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             frame_sync,
  input  logic             out_ack,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);

  // Handshake: out_valid=1 means parallel_out holds a word the consumer has not
  // yet taken; the word is taken on any edge where out_valid and out_ack are
  // both high. A new word may land on that same edge without a valid gap.

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_tc;
  logic             cnt_clr;
  logic             cnt_load1;
  logic             cnt_en;
  logic             complete;
  logic [WIDTH-1:0] word;

  // A sync without a bit re-aligns by zeroing; a sync with a bit makes it bit 0.
  assign cnt_clr   = clr | (frame_sync & ~shift_en);
  assign cnt_load1 = shift_en & frame_sync;
  assign cnt_en    = shift_en & ~frame_sync;
  assign complete  = cnt_en & cnt_tc;
  assign word      = {shreg[WIDTH-2:0], serial_in};

  mod_counter #(
    .MOD (WIDTH),
    .W   (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .en    (cnt_en),
    .cnt   (bit_cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      shreg        <= '0;
      parallel_out <= {WIDTH{PAR_RST_BIT}};
      out_valid    <= VALID_RST;
      overrun      <= OVERRUN_RST;
      busy         <= BUSY_RST;
    end else begin
      if (shift_en)
        shreg <= word;
      if (complete) begin
        if (!out_valid || out_ack) begin
          parallel_out <= word;
          out_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end
      busy <= (bit_cnt != '0);
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed and randomized checks of sipo_deserializer against a word-level model.
module tb_sipo_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         serial_in;
  logic         shift_en;
  logic         frame_sync;
  logic         out_ack;
  logic [W-1:0] parallel_out;
  logic         out_valid;
  logic         overrun;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Reference model: bits collected so far in the current word and output state.
  int           m_len;
  logic [W-1:0] m_bits;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovr;
  logic         m_busy;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .clr          (clr),
    .serial_in    (serial_in),
    .shift_en     (shift_en),
    .frame_sync   (frame_sync),
    .out_ack      (out_ack),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic sin, input logic sen, input logic fs,
                              input logic ack, input logic rst);
    bit done;
    logic [W-1:0] w;
    done = 1'b0;
    if (rst) begin
      m_len = 0; m_bits = '0; m_data = '0;
      m_valid = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      return;
    end
    m_busy = (m_len != 0);
    if (sen) begin
      m_bits = {m_bits[W-2:0], sin};
      if (fs) begin
        m_len = 1;
      end else begin
        m_len = m_len + 1;
        if (m_len == W) begin
          done = 1'b1;
          m_len = 0;
        end
      end
    end else if (fs) begin
      m_len = 0;
    end
    w = m_bits;
    if (done) begin
      if (!m_valid || ack) begin
        m_data = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (ack) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge.
  task automatic step(input logic sin, input logic sen, input logic fs,
                      input logic ack, input logic rst);
    clr = rst; serial_in = sin; shift_en = sen; frame_sync = fs; out_ack = ack;
    model_update(sin, sen, fs, ack, rst);
    @(posedge clk);
    #1;
    check("parallel_out", 32'(parallel_out), 32'(m_data));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 1'b0, 1'b0, ack, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] data, input logic ack_last);
    for (int i = W - 1; i >= 0; i--)
      step(data[i], 1'b1, (i == W - 1), (i == 0) && ack_last, 1'b0);
  endtask

  initial begin
    clr = 1'b1; serial_in = 1'b0; shift_en = 1'b0; frame_sync = 1'b0; out_ack = 1'b0;
    m_len = 0; m_bits = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    @(posedge clk);
    #1;

    // Reset held while data inputs toggle.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_data", 32'(parallel_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single word 0xA5, then ack.
    send_word(8'hA5, 1'b0);
    check("a5_data", 32'(parallel_out), 32'hA5);
    check("a5_valid", 32'(out_valid), 32'h1);
    idle(1'b1);
    check("a5_ack_valid", 32'(out_valid), 32'h0);

    // Gapped word: three idle cycles between bits 4 and 5.
    for (int i = 7; i >= 4; i--)
      step(1'(8'hA5 >> i), 1'b1, (i == 7), 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle(1'b0);
      check("gap_busy", 32'(busy), 32'h1);
    end
    for (int i = 3; i >= 0; i--)
      step(1'(8'hA5 >> i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("gap_data", 32'(parallel_out), 32'hA5);
    check("gap_valid", 32'(out_valid), 32'h1);
    idle(1'b1);

    // Streaming: 0x3C then 0xFF, ack on the 0xFF completion cycle.
    send_word(8'h3C, 1'b0);
    check("stream_3c", 32'(parallel_out), 32'h3C);
    send_word(8'hFF, 1'b1);
    check("stream_ff", 32'(parallel_out), 32'hFF);
    check("stream_valid", 32'(out_valid), 32'h1);
    check("stream_ovr", 32'(overrun), 32'h0);
    idle(1'b1);

    // Overrun: second word dropped, flag sticky through ack until reset.
    send_word(8'h12, 1'b0);
    send_word(8'h34, 1'b0);
    check("ovr_data", 32'(parallel_out), 32'h12);
    check("ovr_flag", 32'(overrun), 32'h1);
    idle(1'b1);
    check("ovr_sticky", 32'(overrun), 32'h1);
    check("ovr_ack_valid", 32'(out_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clr", 32'(overrun), 32'h0);

    // Resync: partial word discarded by a bare frame_sync.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("resync_valid", 32'(out_valid), 32'h0);
    send_word(8'h81, 1'b0);
    check("resync_data", 32'(parallel_out), 32'h81);
    check("resync_valid2", 32'(out_valid), 32'h1);
    check("resync_ovr", 32'(overrun), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(1, 0)),
           ($urandom_range(3, 0) != 0),
           ($urandom_range(40, 0) == 0),
           ($urandom_range(5, 0) == 0),
           ($urandom_range(400, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out deserializer that sits directly downstream of the team's parallel-in serial-out shift register and reassembles its MSB-first bit stream into WIDTH-bit words. A bit counter tracks word boundaries; a `frame_sync` strobe re-aligns it. Completed words are held in an output register under a valid/ack handshake, and a sticky overrun flag records any word lost because the consumer had not acknowledged the previous one.

## Interface
- `WIDTH`, default 8: word width in bits; legal range WIDTH ≥ 2.

- `clk` input 1: single clock; all state updates on rising edge.
- `clr` input 1: synchronous, active-high reset.
- `serial_in` input 1: serial data bit, MSB of each word first.
- `shift_en` input 1: `serial_in` carries a valid bit this cycle.
- `frame_sync` input 1: current or next bit is bit 0 of a new word.
- `out_ack` input 1: consumer accepts `parallel_out`.
- `parallel_out` output WIDTH: last completed word.
- `out_valid` output 1: `parallel_out` holds an unacknowledged word.
- `overrun` output 1: sticky; a completed word was dropped.
- `busy` output 1: a partial word is in progress (`bit_cnt != 0`).

## Operation
- Internal state:
  - shift register `shreg[WIDTH-1:0]`.
  - bit counter `bit_cnt`, range 0..WIDTH-1, `$clog2(WIDTH)` bits.
- Shift: on `shift_en`, `shreg <= {shreg[WIDTH-2:0], serial_in}`. The first-received bit lands in `parallel_out[WIDTH-1]`.
- Count, when `shift_en=1` and `frame_sync=0`:
  - `bit_cnt` increments.
  - At `bit_cnt == WIDTH-1` the word completes and `bit_cnt` wraps to 0.
- Frame sync:
  - `frame_sync=1` with `shift_en=1`: the current bit is bit 0. `shreg` shifts, `bit_cnt <= 1`, and no completion occurs.
  - `frame_sync=1` with `shift_en=0`: `bit_cnt <= 0`. Any partial word is discarded silently (no overrun).
- Completion, where `word = {shreg[WIDTH-2:0], serial_in}`:
  - If `out_valid=0` or `out_ack=1`: `parallel_out <= word` and `out_valid <= 1`.
  - Otherwise: `parallel_out` is unchanged, `out_valid` stays 1, `overrun <= 1`, and the word is dropped.
- Ack: `out_ack=1` with `out_valid=1` and no completion in the same cycle gives `out_valid <= 0`. `out_ack` while `out_valid=0` is ignored.
- `overrun` is cleared only by `clr`.
- Reset (`clr=1`, overrides all other inputs):
  - `shreg=0`, `bit_cnt=0`, `parallel_out=0`.
  - `out_valid=0`, `overrun=0`, `busy=0`.
  - Reset mid-word discards the partial word.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: `out_valid` rises and `parallel_out` updates on the same edge that samples the WIDTH-th bit. They are visible in the cycle after that bit.
- Back-to-back words with `shift_en` held high: one completion every WIDTH cycles. Throughput is lossless if `out_ack` arrives within WIDTH cycles.
- `shift_en` may deassert between any bits. The counter and shift register hold, and there is no timeout.
- A word that completes in the same cycle as `out_ack` replaces the acknowledged word with no `out_valid` gap.
- `busy` follows `bit_cnt` one edge after each update.

## Structure
- Shared package `sipo_pkg` holds:
  - `CNT_W = $clog2(WIDTH)`, as a localparam function of WIDTH.
  - Reset-value constants for the output register.
- One natural sub-module, `mod_counter`: a modulo-WIDTH up-counter with synchronous clear, load-to-1, enable, and a terminal-count output.
- The shift register, output register and handshake logic stay in the top level.

## Test plan
All scenarios use WIDTH=8.
- Reset: `clr=1` for 2 cycles while `serial_in`/`shift_en` toggle → all outputs 0. First word after release decodes correctly.
- Single word: `frame_sync` + bits 1,0,1,0,0,1,0,1 with `shift_en` each cycle → `parallel_out=8'hA5` and `out_valid=1` in the cycle after the 8th bit. `out_ack` → `out_valid=0` next cycle.
- Gapped input: same 0xA5 bits with `shift_en` low for 3 cycles between bits 4 and 5 → `parallel_out=8'hA5`, `busy=1` throughout the gap.
- Streaming with ack on completion cycle: words 0x3C then 0xFF back-to-back, `out_ack` pulsed on the 0xFF completion cycle → `parallel_out=8'hFF`, `out_valid` stays 1, `overrun=0`.
- Overrun: 0x12 then 0x34 with no ack → `parallel_out=8'h12`, `overrun=1` after the 2nd word. The flag persists after `out_ack` and clears only on `clr`.
- Resync: 3 bits sent, then `frame_sync` without `shift_en`, then full 0x81 → `parallel_out=8'h81`, no overrun, no spurious `out_valid`.
